output_serializer: RTL and testbench

OUTPUT_SERIALIZER -- requirements
Module: output_serializer

---
 rtl/output_serializer.sv | 139 +++++++++++++
 tb/tb_output_serializer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_serializer.sv
// output_serializer: captures snapshots of the active monitor streams into a
// small FIFO. It then presents each snapshot one record at a time: the active
// streams in ascending index order, over a valid/ready handshake.
// Optional feature: define OUTPUT_SERIALIZER_DROP_CNT_EN to get a saturating
// dropped-snapshot counter on drop_cnt. When it is undefined, drop_cnt is tied to 0.
module output_serializer #(
  parameter  int NUM_OUT = 9,
  parameter  int DW      = 64,
  parameter  int DEPTH   = 4,
  localparam int SW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_OUT*DW-1:0]    out_val,
  input  logic [NUM_OUT-1:0]       out_aktv,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [SW-1:0]            m_stream,
  output logic signed [DW-1:0]     m_value,
  output logic [31:0]              m_time,
  output logic                     m_last,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [31:0]           r_ts;
  logic [NUM_OUT-1:0]    r_mask [DEPTH];
  logic [NUM_OUT*DW-1:0] r_val  [DEPTH];
  logic [31:0]           r_tsq  [DEPTH];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [AW:0]           r_cnt, w_cnt_nxt;
  logic                  r_overflow;

  logic [NUM_OUT-1:0]    w_head_mask, w_head_rest;
  logic [NUM_OUT*DW-1:0] w_head_val;
  logic [SW-1:0]         w_idx;
  logic signed [DW-1:0]  w_val_sel;
  logic                  w_valid, w_hs, w_pop, w_cap, w_push, w_drop, w_full;

  // The head entry's mask holds the streams not yet emitted.
  // Clearing its lowest set bit yields the mask that remains after this record.
  assign w_head_mask = r_mask[r_rptr];
  assign w_head_val  = r_val[r_rptr];
  assign w_head_rest = w_head_mask & (w_head_mask - NUM_OUT'(1));

  assign w_valid   = (r_state == EMIT) && !rst;
  assign w_hs      = w_valid && m_ready;
  assign w_pop     = w_hs && (w_head_rest == '0);
  assign w_full    = (r_cnt == (AW+1)'(DEPTH));
  assign w_cap     = en && (|out_aktv) && !rst;
  assign w_push    = w_cap && (!w_full || w_pop);
  assign w_drop    = w_cap && !w_push;
  assign w_cnt_nxt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);

  // Pick the lowest-index remaining stream of the head entry and its value.
  always_comb begin
    w_idx     = '0;
    w_val_sel = '0;
    for (int i = NUM_OUT - 1; i >= 0; i--) begin
      if (w_head_mask[i]) begin
        w_idx     = SW'(i);
        w_val_sel = w_head_val[i*DW +: DW];
      end
    end
  end

  assign m_valid  = w_valid;
  assign m_stream = w_valid ? w_idx : '0;
  assign m_value  = w_valid ? w_val_sel : '0;
  assign m_time   = w_valid ? r_tsq[r_rptr] : '0;
  assign m_last   = w_valid && (w_head_rest == '0);
  assign overflow = r_overflow;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: emit whenever the FIFO holds an entry; no bubble between snapshots.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cnt_nxt != '0) w_state_nxt = EMIT;
      EMIT:    if (w_cnt_nxt == '0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Timestamp, FIFO pointers/occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts       <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (en)     r_ts   <= r_ts + 32'd1;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_cnt <= w_cnt_nxt;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Snapshot storage. The handshake retires the presented bit of the head.
  // A push is written after it, so the new snapshot wins when a full FIFO
  // pops and pushes into the same slot.
  always_ff @(posedge clk) begin
    if (w_hs) r_mask[r_rptr] <= w_head_rest;
    if (w_push) begin
      r_mask[r_wptr] <= out_aktv;
      r_val[r_wptr]  <= out_val;
      r_tsq[r_wptr]  <= r_ts;
    end
  end

`ifdef OUTPUT_SERIALIZER_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  // Saturating count of snapshots that found the FIFO full.
  always_ff @(posedge clk) begin
    if (rst)                                    r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_output_serializer.sv
// Bench for output_serializer: a queue-of-records model predicts every
// serialized record, and directed scenarios add hand-computed expectations.
`timescale 1ns/1ps
module tb_output_serializer;

  localparam int NUM_OUT = 9;
  localparam int DW      = 64;
  localparam int DEPTH   = 4;
  localparam int SW      = $clog2(NUM_OUT);
`ifdef OUTPUT_SERIALIZER_DROP_CNT_EN
  localparam int EXP_DROPS = 1;
`else
  localparam int EXP_DROPS = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rst, en, m_ready;
  logic [NUM_OUT*DW-1:0] out_val;
  logic [NUM_OUT-1:0]    out_aktv;
  logic                  m_valid, m_last, overflow;
  logic [SW-1:0]         m_stream;
  logic signed [DW-1:0]  m_value;
  logic [31:0]           m_time;
  logic [15:0]           drop_cnt;

  always #5 clk = ~clk;

  output_serializer #(.NUM_OUT(NUM_OUT), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .out_val(out_val), .out_aktv(out_aktv),
    .m_valid(m_valid), .m_ready(m_ready), .m_stream(m_stream), .m_value(m_value),
    .m_time(m_time), .m_last(m_last), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  typedef struct {
    int unsigned   stream;
    logic [DW-1:0] value;
    logic [31:0]   tstamp;
    bit            last;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        mr;
  int          nsnap = 0;
  logic [31:0] mdl_ts = '0;
  bit          mdl_ovf = 1'b0;
  int          mdl_drops = 0;
  int          hi;
  bit          popped;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_val(input int i, input logic [DW-1:0] v);
    out_val[i*DW +: DW] = v;
  endtask

  // Model: compare this cycle's outputs, then advance to the coming edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (rst) begin
        check("rst_outputs_zero", {63'd0, m_valid} | {63'd0, m_last} | 64'(m_stream) | 64'(m_value) | 64'(m_time), 64'd0);
      end else if (exp_q.size() == 0) begin
        check("mdl_valid_idle", 64'(m_valid), 64'd0);
      end else begin
        check("mdl_valid", 64'(m_valid), 64'd1);
        check("mdl_stream", 64'(m_stream), 64'(exp_q[0].stream));
        check("mdl_value", m_value, exp_q[0].value);
        check("mdl_time", 64'(m_time), 64'(exp_q[0].tstamp));
        check("mdl_last", 64'(m_last), 64'(exp_q[0].last));
      end
      check("mdl_overflow", 64'(overflow), 64'(mdl_ovf));
      check("mdl_drop_cnt", 64'(drop_cnt), 64'(mdl_drops));
    end

    if (rst) begin
      exp_q.delete();
      nsnap     = 0;
      mdl_ts    = '0;
      mdl_ovf   = 1'b0;
      mdl_drops = 0;
    end else begin
      popped = 1'b0;
      if (exp_q.size() > 0 && m_ready) begin
        popped = exp_q[0].last;
        void'(exp_q.pop_front());
        if (popped) nsnap--;
      end
      if (en && (|out_aktv)) begin
        if (nsnap < DEPTH) begin
          hi = -1;
          for (int i = 0; i < NUM_OUT; i++) if (out_aktv[i]) hi = i;
          for (int i = 0; i < NUM_OUT; i++) begin
            if (out_aktv[i]) begin
              mr.stream = i;
              mr.value  = out_val[i*DW +: DW];
              mr.tstamp = mdl_ts;
              mr.last   = (i == hi);
              exp_q.push_back(mr);
            end
          end
          nsnap++;
        end else begin
          mdl_ovf = 1'b1;
`ifdef OUTPUT_SERIALIZER_DROP_CNT_EN
          if (mdl_drops < 65535) mdl_drops++;
`endif
        end
      end
      if (en) mdl_ts = mdl_ts + 32'd1;
    end
  end

  int hs;

  initial begin
    rst = 1'b1; en = 1'b0; m_ready = 1'b0; out_aktv = '0; out_val = '0;
    tick;
    chk_en = 1'b1;
    tick; tick;
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst = 1'b0;

    // Scenario 1: streams 0 and 2 captured at timestamp 5
    m_ready = 1'b1; en = 1'b1;
    repeat (5) tick;
    out_aktv = 9'b000000101; set_val(0, 64'd7); set_val(2, -64'sd3);
    tick;
    en = 1'b0; out_aktv = '0;
    check("s1_r0_valid", 64'(m_valid), 64'd1);
    check("s1_r0_stream", 64'(m_stream), 64'd0);
    check("s1_r0_value", m_value, 64'd7);
    check("s1_r0_time", 64'(m_time), 64'd5);
    check("s1_r0_last", 64'(m_last), 64'd0);
    tick;
    check("s1_r1_stream", 64'(m_stream), 64'd2);
    check("s1_r1_value", m_value, 64'hFFFF_FFFF_FFFF_FFFD);
    check("s1_r1_time", 64'(m_time), 64'd5);
    check("s1_r1_last", 64'(m_last), 64'd1);
    tick;
    check("s1_idle", 64'(m_valid), 64'd0);

    // Scenario 6: en low gates capture and the timestamp
    en = 1'b0; out_aktv = '1;
    repeat (10) tick;
    check("s6_no_capture", 64'(m_valid), 64'd0);
    m_ready = 1'b0; en = 1'b1; out_aktv = 9'b000010000; set_val(4, 64'd123);
    tick;
    en = 1'b0; out_aktv = '0;
    check("s6_time_held", 64'(m_time), 64'd6);
    check("s6_stream", 64'(m_stream), 64'd4);
    m_ready = 1'b1;
    tick;
    check("s6_drained", 64'(m_valid), 64'd0);

    // Scenario 2: five snapshots into a stalled 4-deep FIFO
    m_ready = 1'b0; en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      out_aktv = NUM_OUT'(1) << k;
      set_val(k, 64'(100 + k));
      tick;
    end
    en = 1'b0; out_aktv = '0;
    check("s2_overflow", 64'(overflow), 64'd1);
    check("s2_drop_cnt", 64'(drop_cnt), 64'(EXP_DROPS));
    check("s2_head_stream", 64'(m_stream), 64'd0);
    check("s2_head_time", 64'(m_time), 64'd7);
    m_ready = 1'b1;
    tick;
    check("s2_r1_stream", 64'(m_stream), 64'd1);
    check("s2_r1_time", 64'(m_time), 64'd8);
    tick; tick;
    check("s2_r3_stream", 64'(m_stream), 64'd3);
    check("s2_r3_value", m_value, 64'd103);
    check("s2_r3_time", 64'(m_time), 64'd10);
    tick;
    check("s2_drained", 64'(m_valid), 64'd0);

    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("s3_pre_overflow", 64'(overflow), 64'd0);

    // Scenario 3: push into a full FIFO in the same cycle as a final pop
    m_ready = 1'b0; en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      out_aktv = 9'b1;
      set_val(0, 64'(200 + k));
      tick;
    end
    check("s3_full_last", 64'(m_last), 64'd1);
    out_aktv = 9'b000001000; set_val(3, 64'd555); m_ready = 1'b1;
    tick;
    en = 1'b0; out_aktv = '0;
    check("s3_overflow", 64'(overflow), 64'd0);
    check("s3_next_value", m_value, 64'd201);
    check("s3_next_time", 64'(m_time), 64'd1);
    tick; tick; tick;
    check("s3_new_stream", 64'(m_stream), 64'd3);
    check("s3_new_value", m_value, 64'd555);
    check("s3_new_time", 64'(m_time), 64'd4);
    tick;
    check("s3_drained", 64'(m_valid), 64'd0);

    // Scenario 4: all nine streams with a randomly stalling consumer
    m_ready = 1'b0; en = 1'b1; out_aktv = '1;
    for (int i = 0; i < NUM_OUT; i++) set_val(i, 64'(i * 1000 - 4000));
    tick;
    en = 1'b0; out_aktv = '0;
    hs = 0;
    for (int k = 0; k < 300 && exp_q.size() > 0; k++) begin
      m_ready = 1'($urandom_range(0, 1));
      if (m_valid && m_ready) hs++;
      tick;
    end
    check("s4_drained", 64'(exp_q.size()), 64'd0);
    check("s4_handshakes", 64'(hs), 64'd9);
    check("s4_idle", 64'(m_valid), 64'd0);

    // Scenario 5: reset after two of nine records
    m_ready = 1'b0; en = 1'b1; out_aktv = '1;
    tick;
    en = 1'b0; out_aktv = '0; m_ready = 1'b1;
    tick; tick;
    check("s5_mid_stream", 64'(m_stream), 64'd2);
    rst = 1'b1;
    tick;
    rst = 1'b0; m_ready = 1'b0;
    check("s5_valid_after_rst", 64'(m_valid), 64'd0);
    check("s5_overflow", 64'(overflow), 64'd0);
    tick;
    check("s5_still_idle", 64'(m_valid), 64'd0);
    en = 1'b1; out_aktv = 9'b000000010;
    tick;
    en = 1'b0; out_aktv = '0;
    check("s5_time_restart", 64'(m_time), 64'd0);
    check("s5_stream", 64'(m_stream), 64'd1);
    m_ready = 1'b1;
    tick;
    check("s5_drained", 64'(m_valid), 64'd0);
    tick; tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
